geofence_result_collector: RTL
==============================

# geofence_result_collector

Downstream stage of the geofence core: it consumes the core's single-cycle `valid`/`is_inside` result pulse, tags each result with a sequential object ID, and queues it in a FIFO with a valid/ready read port. It also keeps saturating statistics counters and sticky error flags. It sits between the geofence core and the host readout logic, so a slow consumer never loses results while the core free-runs.

## Interface
- `FIFO_DEPTH`, 8: result queue entries; power of two, at least 2.
- `ID_W`, 8: object ID width; the ID wraps modulo 2^ID_W.
- `CNT_W`, 16: width of the statistics counters.
- `WDOG_CYCLES`, 256: watchdog limit in cycles; only used with `GEOFENCE_COLLECTOR_WDOG_EN`.
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `gf_valid`  in  1  result strobe from the geofence core
- `gf_is_inside`  in  1  result bit; only meaningful when `gf_valid`=1
- `clr`  in  1  synchronous clear of queue, IDs, counters and flags
- `out_valid`  out  1  queue head is available
- `out_ready`  in  1  consumer accepts the head
- `out_id`  out  ID_W  object ID of the head entry
- `out_inside`  out  1  inside bit of the head entry
- `total_cnt`  out  CNT_W  number of results received (saturating)
- `inside_cnt`  out  CNT_W  number of results with inside=1 (saturating)
- `overflow`  out  1  sticky: a result was dropped because the queue was full
- `timeout`  out  1  sticky: watchdog expired; constant 0 when the watchdog is compiled out

## Operation
- Reset is asynchronous, active-high; clock is `clk`. On reset all outputs are 0, the queue is empty, the next ID is 0 and the watchdog is ARMED with a count of 0.
- Every cycle with `gf_valid`=1 is one result. Record = {next ID, `gf_is_inside`}. After each result the next ID increments, including when the result is dropped.
- Push: the record is written at the clock edge that samples `gf_valid`.
  - Queue not full: the record is stored.
  - Queue full and a pop happens in the same cycle: both succeed and occupancy stays at FIFO_DEPTH.
  - Queue full and no pop: the record is dropped and `overflow` is set.
- Pop: happens when `out_valid` & `out_ready`. The read port is first-word-fall-through: `out_id` and `out_inside` always show the head entry. `out_ready` while empty has no effect.
- Counters: `total_cnt` increments on every result. `inside_cnt` increments when the result's inside bit is 1. Dropped results are counted. Both counters hold at 2^CNT_W−1.
- `clr` takes priority over everything in the same cycle. It empties the queue, sets the next ID to 0, zeroes the counters, clears both sticky flags and re-arms the watchdog. A `gf_valid` in the same cycle as `clr` is discarded.
- Watchdog FSM, states ARMED and EXPIRED:
  - ARMED: the cycle counter increments every cycle. `gf_valid` resets it to 0. When it reaches WDOG_CYCLES−1 without a `gf_valid`, the FSM moves to EXPIRED and `timeout` is set.
  - EXPIRED: the counter is frozen. `gf_valid` returns the FSM to ARMED with a count of 0; `timeout` stays set.
  - Reset or `clr`: ARMED, count 0.

## Timing
- Latency: a result sampled at edge N is visible as `out_valid`=1 in the cycle after edge N, provided the queue was empty.
- A pop at edge N shows the next head, or `out_valid`=0, after edge N.
- Counters and `overflow` update at the same edge as the push.
- `timeout` goes high after the edge that ends the WDOG_CYCLES-th consecutive cycle without `gf_valid`.
- Full throughput: one push and one pop per cycle.

## Configuration
- `GEOFENCE_COLLECTOR_WDOG_EN` defined: the watchdog FSM and counter are built, and `timeout` behaves as specified above.
- Not defined: no watchdog logic is built, `timeout` is tied to 0, and `WDOG_CYCLES` is ignored.

## Test plan
- After reset, pulse `gf_valid` 3 times with inside=1,0,1 and hold `out_ready`=0 → `out_valid`=1; entries (0,1),(1,0),(2,1) pop in order; `total_cnt`=3, `inside_cnt`=2.
- Hold `out_ready`=0 and send 9 results with FIFO_DEPTH=8 → `overflow`=1; the queue holds IDs 0–7; `total_cnt`=9; the next result gets ID 9.
- With the queue full, assert `gf_valid` and `out_ready` in the same cycle → ID 0 pops, the new ID is stored, `overflow` stays 0.
- Assert `clr` in the same cycle as `gf_valid` → queue empty, counters 0, and the next accepted result has ID 0.
- With the macro defined and WDOG_CYCLES=16, keep `gf_valid`=0 for 16 cycles after reset → `timeout`=1. A later `gf_valid` leaves `timeout`=1; `clr` clears it. Without the macro, `timeout` stays 0.
- With ID_W=2, send 5 results → IDs 0,1,2,3,0.

Source files
------------

// File: rtl/geofence_result_collector.sv
// geofence_result_collector: tags each geofence core result with a sequential
// object ID and queues it in a first-word-fall-through FIFO with a valid/ready
// read port. It also keeps saturating result counters and sticky overflow and
// timeout flags.
// Optional feature: define GEOFENCE_COLLECTOR_WDOG_EN to build the idle watchdog.
// Without it, o_timeout is tied to 0 and WDOG_CYCLES is ignored.
module geofence_result_collector #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned ID_W        = 8,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned WDOG_CYCLES = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_gf_valid,
  input  logic             i_gf_is_inside,
  input  logic             i_clr,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [ID_W-1:0]  o_out_id,
  output logic             o_out_inside,
  output logic [CNT_W-1:0] o_total_cnt,
  output logic [CNT_W-1:0] o_inside_cnt,
  output logic             o_overflow,
  output logic             o_timeout
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned RW = ID_W + 1;

  // Each record is {id, inside}.
  logic [RW-1:0]    r_mem [FIFO_DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [ID_W-1:0]  r_next_id;
  logic [CNT_W-1:0] r_total_cnt;
  logic [CNT_W-1:0] r_inside_cnt;
  logic             r_overflow;

  logic          w_empty;
  logic          w_full;
  logic          w_result;
  logic          w_pop;
  logic          w_push;
  logic [RW-1:0] w_head;

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // A result coinciding with clr is discarded.
  assign w_result = i_gf_valid & ~i_clr;
  assign w_pop    = ~w_empty & i_out_ready;
  // A full queue still accepts when the head leaves in the same cycle.
  assign w_push   = w_result & (~w_full | w_pop);
  assign w_head   = r_mem[r_rd_ptr[AW-1:0]];

  assign o_out_valid  = ~w_empty;
  assign o_out_id     = w_empty ? '0 : w_head[RW-1:1];
  assign o_out_inside = ~w_empty & w_head[0];
  assign o_total_cnt  = r_total_cnt;
  assign o_inside_cnt = r_inside_cnt;
  assign o_overflow   = r_overflow;

  // Queue storage; contents are only observed through the non-empty head.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {r_next_id, i_gf_is_inside};
    end
  end

  // Queue pointers and next object ID.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_next_id <= '0;
    end else if (i_clr) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_next_id <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      // The ID advances for dropped results too.
      if (w_result) r_next_id <= r_next_id + 1'b1;
    end
  end

  // Saturating statistics counters and the sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_total_cnt  <= '0;
      r_inside_cnt <= '0;
      r_overflow   <= 1'b0;
    end else if (i_clr) begin
      r_total_cnt  <= '0;
      r_inside_cnt <= '0;
      r_overflow   <= 1'b0;
    end else if (w_result) begin
      if (r_total_cnt != '1) r_total_cnt <= r_total_cnt + 1'b1;
      if (i_gf_is_inside && (r_inside_cnt != '1)) r_inside_cnt <= r_inside_cnt + 1'b1;
      if (w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

`ifdef GEOFENCE_COLLECTOR_WDOG_EN
  localparam int unsigned WCW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WCW-1:0] WD_LAST = WCW'(WDOG_CYCLES - 1);

  typedef enum logic {StArmed, StExpired} wd_state_t;

  wd_state_t      r_wd_state;
  wd_state_t      w_wd_state_nxt;
  logic [WCW-1:0] r_wd_cnt;
  logic [WCW-1:0] w_wd_cnt_nxt;
  logic           r_timeout;
  logic           w_timeout_nxt;

  // Watchdog state, idle-cycle count and sticky timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wd_state <= StArmed;
      r_wd_cnt   <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_wd_state <= w_wd_state_nxt;
      r_wd_cnt   <= w_wd_cnt_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  // Watchdog next state: count idle cycles, expire on the last one.
  always_comb begin
    w_wd_state_nxt = r_wd_state;
    w_wd_cnt_nxt   = r_wd_cnt;
    w_timeout_nxt  = r_timeout;
    if (i_clr) begin
      w_wd_state_nxt = StArmed;
      w_wd_cnt_nxt   = '0;
      w_timeout_nxt  = 1'b0;
    end else begin
      unique case (r_wd_state)
        StArmed: begin
          if (i_gf_valid) begin
            w_wd_cnt_nxt = '0;
          end else if (r_wd_cnt == WD_LAST) begin
            w_wd_state_nxt = StExpired;
            w_timeout_nxt  = 1'b1;
          end else begin
            w_wd_cnt_nxt = r_wd_cnt + 1'b1;
          end
        end
        StExpired: begin
          // Count stays frozen; activity re-arms but the flag stays sticky.
          if (i_gf_valid) begin
            w_wd_state_nxt = StArmed;
            w_wd_cnt_nxt   = '0;
          end
        end
        default: begin
          w_wd_state_nxt = StArmed;
          w_wd_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign o_timeout = r_timeout;
`else
  logic w_unused_wdog;
  assign w_unused_wdog = ^WDOG_CYCLES;
  assign o_timeout     = 1'b0;
`endif

endmodule
